// File: rtl/rgmii_tx_framer.sv
// RGMII transmit byte framer: preamble/SFD, payload, optional pad + CRC-32 FCS, IFG.
// Define TX_FCS_PAD_EN to build the PAD/FCS path; otherwise upstream supplies the FCS.
module rgmii_tx_framer #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic [7:0] dataIn,
    input  logic       validIn,
    input  logic       lastIn,
    output logic       readyOut,
    output logic [3:0] txDataRiseOut,
    output logic [3:0] txDataFallOut,
    output logic       txCtrlRiseOut,
    output logic       txCtrlFallOut,
    output logic       busyOut,
    output logic       underrunOut
);
    localparam int CW = $clog2(IFG_BYTES + 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(6);
    localparam logic [CW-1:0] FCS_LAST = CW'(3);
    // The IDLE cycle that follows IFG emits the final idle byte, so IFG runs one short.
    localparam logic [CW-1:0] IFG_LAST = CW'(IFG_BYTES - 2);

    typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG} state_t;

    state_t        state, state_next;
    logic [CW-1:0] seq, seq_next;
    logic [7:0]    tx_byte, byte_next;
    logic          ctrl_rise, ctrl_fall, rise_next, fall_next;
    logic          underrun, underrun_next, busy;

`ifdef TX_FCS_PAD_EN
    localparam logic [5:0] MIN_CNT = 6'(MIN_PAYLOAD);
    localparam logic [5:0] MIN_M1  = 6'(MIN_PAYLOAD - 1);

    logic [5:0]  cnt, cnt_next;
    logic [31:0] crc, crc_next, fcs;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign fcs = ~crc;
`endif

    assign readyOut      = (state == DATA);
    assign txDataRiseOut = tx_byte[3:0];
    assign txDataFallOut = tx_byte[7:4];
    assign txCtrlRiseOut = ctrl_rise;
    assign txCtrlFallOut = ctrl_fall;
    assign busyOut       = busy;
    assign underrunOut   = underrun;

    always_comb begin
        state_next    = state;
        seq_next      = seq;
        byte_next     = 8'h00;
        rise_next     = 1'b0;
        fall_next     = 1'b0;
        underrun_next = 1'b0;
`ifdef TX_FCS_PAD_EN
        cnt_next      = cnt;
        crc_next      = crc;
`endif
        case (state)
            IDLE: if (validIn) begin
                state_next = PRE;
                seq_next   = '0;
`ifdef TX_FCS_PAD_EN
                cnt_next   = '0;
                crc_next   = '1;
`endif
            end
            PRE: begin
                byte_next = 8'h55;
                rise_next = 1'b1;
                fall_next = 1'b1;
                if (seq == PRE_LAST) begin
                    state_next = SFD;
                    seq_next   = '0;
                end else begin
                    seq_next = seq + 1'b1;
                end
            end
            SFD: begin
                byte_next  = 8'hD5;
                rise_next  = 1'b1;
                fall_next  = 1'b1;
                state_next = DATA;
            end
            DATA: if (validIn) begin
                byte_next = dataIn;
                rise_next = 1'b1;
                fall_next = 1'b1;
`ifdef TX_FCS_PAD_EN
                crc_next  = crc_byte(crc, dataIn);
                if (cnt < MIN_CNT) cnt_next = cnt + 6'd1;
                if (lastIn) begin
                    state_next = (cnt < MIN_M1) ? PAD : FCS;
                    seq_next   = '0;
                end
`else
                if (lastIn) begin
                    state_next = IFG;
                    seq_next   = '0;
                end
`endif
            end else begin
                // Starved mid-frame: the error-marked byte goes out in place of the missing one.
                rise_next     = 1'b1;
                underrun_next = 1'b1;
                state_next    = ERR;
            end
`ifdef TX_FCS_PAD_EN
            PAD: begin
                rise_next = 1'b1;
                fall_next = 1'b1;
                crc_next  = crc_byte(crc, 8'h00);
                if (cnt < MIN_CNT) cnt_next = cnt + 6'd1;
                if (cnt >= MIN_M1) begin
                    state_next = FCS;
                    seq_next   = '0;
                end
            end
            FCS: begin
                byte_next = fcs[{seq[1:0], 3'b000} +: 8];
                rise_next = 1'b1;
                fall_next = 1'b1;
                if (seq == FCS_LAST) begin
                    state_next = IFG;
                    seq_next   = '0;
                end else begin
                    seq_next = seq + 1'b1;
                end
            end
`endif
            // ERR emits the first idle byte of the gap, so IFG resumes the count at one.
            ERR: begin
                state_next = IFG;
                seq_next   = CW'(1);
            end
            IFG: begin
                if (seq == IFG_LAST) state_next = IDLE;
                else                 seq_next   = seq + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state     <= IDLE;
            seq       <= '0;
            tx_byte   <= 8'h00;
            ctrl_rise <= 1'b0;
            ctrl_fall <= 1'b0;
            underrun  <= 1'b0;
            busy      <= 1'b0;
`ifdef TX_FCS_PAD_EN
            cnt       <= '0;
            crc       <= '1;
`endif
        end else begin
            state     <= state_next;
            seq       <= seq_next;
            tx_byte   <= byte_next;
            ctrl_rise <= rise_next;
            ctrl_fall <= fall_next;
            underrun  <= underrun_next;
            busy      <= (state_next != IDLE);
`ifdef TX_FCS_PAD_EN
            cnt       <= cnt_next;
            crc       <= crc_next;
`endif
        end
    end
endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Self-checking bench for rgmii_tx_framer: random frames against a frame-level stream model.
module tb_rgmii_tx_framer;
    localparam int IFG  = 12;
    localparam int MINP = 60;
    localparam logic [10:0] IDLE_S = 11'h000;

    logic       clkIn = 1'b0;
    logic       rstIn = 1'b1;
    logic [7:0] dataIn = 8'h00;
    logic       validIn = 1'b0;
    logic       lastIn = 1'b0;
    logic       readyOut, txCtrlRiseOut, txCtrlFallOut, busyOut, underrunOut;
    logic [3:0] txDataRiseOut, txDataFallOut;

    int checks = 0;
    int errors = 0;

    // Input stream {last, byte}, dropped index (-1 = none), expected and observed
    // symbols {underrun, ctrl_rise, ctrl_fall, byte}.
    logic [8:0]  in_q[$];
    int          drop_at;
    logic [10:0] exp_q[$];
    logic [10:0] obs_q[$];
    logic        busy_q[$];
    int          ready_first;

    always #4 clkIn = ~clkIn;

    rgmii_tx_framer #(.IFG_BYTES(IFG), .MIN_PAYLOAD(MINP)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .dataIn(dataIn), .validIn(validIn), .lastIn(lastIn),
        .readyOut(readyOut), .txDataRiseOut(txDataRiseOut), .txDataFallOut(txDataFallOut),
        .txCtrlRiseOut(txCtrlRiseOut), .txCtrlFallOut(txCtrlFallOut),
        .busyOut(busyOut), .underrunOut(underrunOut)
    );

    // Bit-serial reflected CRC-32, no final inversion.
    function automatic logic [31:0] crc_ref(input logic [7:0] b[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        logic        fb;
        foreach (b[i])
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ b[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        return c;
    endfunction

    function automatic void build_model(input int tail);
        logic [7:0]  cur[$];
        logic [31:0] f;
        bit          start = 1;
        exp_q.delete();
        exp_q.push_back(IDLE_S);
        foreach (in_q[i]) begin
            if (start) begin
                repeat (7) exp_q.push_back({3'b011, 8'h55});
                exp_q.push_back({3'b011, 8'hD5});
                start = 0;
            end
            if (i == drop_at) begin
                exp_q.push_back({3'b110, 8'h00});
                repeat (IFG) exp_q.push_back(IDLE_S);
                break;
            end
            exp_q.push_back({3'b011, in_q[i][7:0]});
            cur.push_back(in_q[i][7:0]);
            if (in_q[i][8]) begin
`ifdef TX_FCS_PAD_EN
                while (cur.size() < MINP) begin
                    cur.push_back(8'h00);
                    exp_q.push_back({3'b011, 8'h00});
                end
                f = ~crc_ref(cur);
                for (int k = 0; k < 4; k++) exp_q.push_back({3'b011, f[8*k +: 8]});
`endif
                repeat (IFG) exp_q.push_back(IDLE_S);
                cur.delete();
                start = 1;
            end
        end
        repeat (tail) exp_q.push_back(IDLE_S);
    endfunction

    task automatic add_frame(input int len);
        for (int i = 0; i < len; i++) in_q.push_back({i == len - 1, 8'($urandom)});
    endtask

    task automatic set_inputs(input int idx);
        if (idx < in_q.size() && idx != drop_at) begin
            validIn = 1'b1;
            dataIn  = in_q[idx][7:0];
            lastIn  = in_q[idx][8];
        end else begin
            validIn = 1'b0;
            dataIn  = 8'($urandom);
            lastIn  = 1'($urandom);
        end
    endtask

    // Stream in_q with validIn held high; capture outputs #1 after each rising edge.
    task automatic run_stream(input int ncyc);
        int   idx = 0;
        logic rdy;
        obs_q.delete();
        busy_q.delete();
        ready_first = -1;
        @(negedge clkIn);
        set_inputs(idx);
        for (int c = 0; c < ncyc; c++) begin
            rdy = readyOut;
            @(posedge clkIn);
            if (validIn && rdy) idx++;
            #1;
            obs_q.push_back({underrunOut, txCtrlRiseOut, txCtrlFallOut, txDataFallOut, txDataRiseOut});
            busy_q.push_back(busyOut);
            if (readyOut && ready_first < 0) ready_first = c;
            set_inputs(idx);
        end
        validIn = 1'b0;
        lastIn  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clkIn);
        checks++;
        if ({txDataRiseOut, txDataFallOut, txCtrlRiseOut, txCtrlFallOut, busyOut, underrunOut, readyOut} !== 15'h0) begin
            errors++;
            $display("FAIL reset_state got %h%h %b%b%b%b%b exp all zero", txDataFallOut, txDataRiseOut,
                     txCtrlRiseOut, txCtrlFallOut, busyOut, underrunOut, readyOut);
        end
        rstIn = 1'b0;
        repeat (2) @(negedge clkIn);
        checks++;
        if ({busyOut, readyOut} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b ready=%b exp 0 0", busyOut, readyOut);
        end
    endtask

    task automatic test_crc_vector();
        logic [7:0] fb[$];
        in_q.delete();
        drop_at = -1;
        for (int i = 0; i < 9; i++) in_q.push_back({i == 8, 8'h31 + 8'(i)});
        build_model(3);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL crc_vector[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (obs_q[1] !== {3'b011, 8'h55} || obs_q[8] !== {3'b011, 8'hD5}) begin
            errors++;
            $display("FAIL preamble_latency got %h/%h exp 355/3d5", obs_q[1], obs_q[8]);
        end
        checks++;
        if (ready_first != 8) begin
            errors++;
            $display("FAIL ready_first got %0d exp 8", ready_first);
        end
        checks++;
        if (busy_q[0] !== 1'b1 || busy_q[busy_q.size()-1] !== 1'b0) begin
            errors++;
            $display("FAIL busy_span got %b..%b exp 1..0", busy_q[0], busy_q[busy_q.size()-1]);
        end
`ifdef TX_FCS_PAD_EN
        for (int i = 9; i < 9 + MINP + 4; i++) fb.push_back(obs_q[i][7:0]);
        checks++;
        if (crc_ref(fb) !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL crc_residue got %h exp debb20e3", crc_ref(fb));
        end
`endif
    endtask

    task automatic test_long_frame();
        logic [7:0] fb[$];
        in_q.delete();
        drop_at = -1;
        add_frame(100);
        build_model(3);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL long_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
`ifdef TX_FCS_PAD_EN
        for (int i = 9; i < 9 + 104; i++) fb.push_back(obs_q[i][7:0]);
        checks++;
        if (crc_ref(fb) !== 32'hDEBB20E3) begin
            errors++;
            $display("FAIL long_residue got %h exp debb20e3", crc_ref(fb));
        end
`endif
    endtask

    task automatic test_min_boundary();
        int lens[5] = '{1, 58, 59, 60, 61};
        foreach (lens[n]) begin
            in_q.delete();
            drop_at = -1;
            add_frame(lens[n]);
            build_model(2);
            run_stream(exp_q.size());
            foreach (exp_q[i]) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL boundary_len%0d[%0d] got %h exp %h", lens[n], i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_underrun();
        int pulses = 0;
        in_q.delete();
        add_frame(30);
        drop_at = 20;
        build_model(4);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL underrun[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
            pulses += int'(obs_q[i][10]);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL underrun_pulses got %0d exp 1", pulses);
        end
        drop_at = -1;
    endtask

    task automatic test_back_to_back();
        in_q.delete();
        drop_at = -1;
        add_frame(int'($urandom_range(1, 70)));
        add_frame(int'($urandom_range(1, 70)));
        add_frame(int'($urandom_range(55, 90)));
        build_model(3);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL back_to_back[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        in_q.delete();
        drop_at = -1;
        add_frame(40);
        run_stream(20);
        #2 rstIn = 1'b1;
        #1;
        checks++;
        if ({txDataRiseOut, txDataFallOut, txCtrlRiseOut, txCtrlFallOut, busyOut, underrunOut, readyOut} !== 15'h0) begin
            errors++;
            $display("FAIL async_reset got %h%h %b%b%b%b%b exp all zero", txDataFallOut, txDataRiseOut,
                     txCtrlRiseOut, txCtrlFallOut, busyOut, underrunOut, readyOut);
        end
        @(posedge clkIn);
        @(negedge clkIn);
        rstIn = 1'b0;
        @(negedge clkIn);
        in_q.delete();
        add_frame(int'($urandom_range(5, 30)));
        build_model(2);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL after_reset[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_short_frame();
        in_q.delete();
        drop_at = -1;
        add_frame(10);
        build_model(3);
        run_stream(exp_q.size());
        foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL short_frame[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        drop_at = -1;
        test_reset();
        test_crc_vector();
        test_long_frame();
        test_min_boundary();
        test_underrun();
        test_back_to_back();
        test_reset_mid_frame();
        test_short_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
